regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a pending-result scoreboard.
// Reads are combinational, with write-through bypass. One pend bit per register
// tracks results that are still in flight. pend_cnt holds the registered count
// of pend bits that are set.
//
// Issue handshake: the issuer drives iss_en/iss_addr. The same cycle, iss_stall
// says whether the issue was taken. iss_stall=1 means the issue was rejected,
// changed no state, and must be presented again. iss_stall=0 with iss_en=1
// means the issue was accepted at that clock edge.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [NREAD*ADDR_W-1:0]   raddr,
   output logic [NREAD*DATA_W-1:0]   rdata,
   output logic [NREAD-1:0]          rrdy,
   input  logic                      iss_en,
   input  logic [ADDR_W-1:0]         iss_addr,
   output logic                      iss_stall,
   output logic [ADDR_W:0]           pend_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = ADDR_W + 1;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nxt;
   logic              wr_ok;
   logic              iss_is_zero;
   logic              iss_ok;
   logic              set_new;
   logic              clr_old;

   // Qualify the write and issue requests and derive the scoreboard updates.
   // Gating on rst_n keeps bypass and stall quiet while the block is held in reset.
   always_comb begin
      wr_ok       = rst_n && we && !((ZERO_REG != 0) && (waddr == '0));
      iss_is_zero = (ZERO_REG != 0) && (iss_addr == '0);
      // A write to the same register this cycle retires the old producer, so no WAW stall.
      iss_stall   = rst_n && iss_en && pend[iss_addr] && !(wr_ok && (waddr == iss_addr));
      iss_ok      = rst_n && iss_en && !iss_stall && !iss_is_zero;
      // The count moves only when a bit really changes.
      // When the write and the issue hit the same register, the issue wins.
      set_new     = iss_ok && !pend[iss_addr];
      clr_old     = wr_ok && pend[waddr] && !(iss_ok && (iss_addr == waddr));
      pend_nxt    = pend;
      if (wr_ok)  pend_nxt[waddr]    = 1'b0;
      if (iss_ok) pend_nxt[iss_addr] = 1'b1;
   end

   // Combinational read ports: the zero register first, then the bypass, then the array.
   always_comb begin
      rdata = '0;
      rrdy  = '0;
      for (int i = 0; i < NREAD; i++) begin : rd_port
         logic [ADDR_W-1:0] ra;
         ra = raddr[i*ADDR_W +: ADDR_W];
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rdata[i*DATA_W +: DATA_W] = '0;
            rrdy[i]                   = 1'b1;
         end else if (wr_ok && (waddr == ra)) begin
            rdata[i*DATA_W +: DATA_W] = wdata;
            rrdy[i]                   = 1'b1;
         end else begin
            rdata[i*DATA_W +: DATA_W] = regs[ra];
            rrdy[i]                   = !pend[ra];
         end
      end
   end

   // Register array storage. It is cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
      end else if (wr_ok) begin
         regs[waddr] <= wdata;
      end
   end

   // Scoreboard pend bits. Reset drops every in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= '0;
      else        pend <= pend_nxt;
   end

   // Count of pending registers, kept in step with the pend bits.
   // A bit cannot be set twice or cleared twice, so the count neither overflows nor wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_cnt <= '0;
      else        pend_cnt <= pend_cnt + CW'(set_new) - CW'(clr_old);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed-vector bench for regfile_sb
// (DATA_W=32, ADDR_W=5, NREAD=2, ZERO_REG=1).
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rrdy;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        iss_stall;
   logic [5:0]  pend_cnt;

   int checks   = 0;
   int failures = 0;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr    (raddr),
      .rdata    (rdata),
      .rrdy     (rrdy),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_stall(iss_stall),
      .pend_cnt (pend_cnt)
   );

   // Clock and reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Wait for the next edge. Inputs and outputs then move 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      raddr = {a1, a0};
   endtask

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia);
      we = w; waddr = wa; wdata = wd; iss_en = ie; iss_addr = ia;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      set_rd(5'd5, 5'd9);
      #2;
      check("reset_pend_cnt", pend_cnt, 6'd0);
      check("reset_rrdy", rrdy, 2'b11);
      check("reset_rdata", rdata, 64'h0);

      // Writes and issues presented during reset are ignored
      drive(1'b1, 5'd5, 32'h1111_2222, 1'b1, 5'd9);
      #1;
      check("reset_no_bypass", rdata, 64'h0);
      check("reset_no_stall", iss_stall, 1'b0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_r5", rdata[31:0], 32'h0);
      check("post_reset_cnt", pend_cnt, 6'd0);
      tick();

      // Write r5, then read it on both ports
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
      set_rd(5'd9, 5'd10);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      set_rd(5'd5, 5'd5);
      #1;
      check("r5_port0", rdata[31:0], 32'hDEAD_BEEF);
      check("r5_port1", rdata[63:32], 32'hDEAD_BEEF);
      check("r5_rrdy", rrdy, 2'b11);

      // Write-through bypass
      drive(1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
      set_rd(5'd7, 5'd5);
      #1;
      check("bypass_rdata0", rdata[31:0], 32'h12);
      check("bypass_rrdy0", rrdy[0], 1'b1);
      check("bypass_other_port", rdata[63:32], 32'hDEAD_BEEF);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      check("r7_stored", rdata[31:0], 32'h12);

      // Issue r3, then re-issue it: WAW stall
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
      set_rd(5'd3, 5'd7);
      #1;
      check("iss3_no_stall", iss_stall, 1'b0);
      tick();
      #1;
      check("iss3_cnt", pend_cnt, 6'd1);
      check("iss3_rrdy0", rrdy[0], 1'b0);
      check("reiss3_stall", iss_stall, 1'b1);
      tick();
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
      #1;
      check("reiss3_cnt", pend_cnt, 6'd1);
      check("wr_iss3_no_stall", iss_stall, 1'b0);
      check("wr_iss3_bypass", rdata[31:0], 32'h33);
      check("wr_iss3_rrdy", rrdy[0], 1'b1);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      check("wr_iss3_cnt", pend_cnt, 6'd1);
      check("wr_iss3_data", rdata[31:0], 32'h33);
      check("wr_iss3_pending", rrdy[0], 1'b0);

      // Retire r3. A second write to the same, now-clear register must not decrement the count.
      drive(1'b1, 5'd3, 32'h44, 1'b0, 5'd0);
      tick();
      #1;
      check("clr3_cnt", pend_cnt, 6'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      check("clr_clear_cnt", pend_cnt, 6'd0);
      check("r3_final", rdata[31:0], 32'h44);

      // Zero register ignores writes and issues
      drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0);
      set_rd(5'd0, 5'd0);
      #1;
      check("r0_no_stall", iss_stall, 1'b0);
      check("r0_bypass_zero", rdata, 64'h0);
      check("r0_rrdy", rrdy, 2'b11);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      check("r0_read_zero", rdata, 64'h0);
      check("r0_cnt", pend_cnt, 6'd0);

      // Issue r1, r2, r4, then write r2 while issuing r6
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      check("three_pend_cnt", pend_cnt, 6'd3);
      drive(1'b1, 5'd2, 32'hAB, 1'b1, 5'd6);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      set_rd(5'd2, 5'd6);
      #1;
      check("swap_cnt", pend_cnt, 6'd3);
      check("swap_rrdy", rrdy, 2'b01);
      check("swap_r2", rdata[31:0], 32'hAB);

      // Asynchronous reset mid-cycle with three registers pending
      set_rd(5'd5, 5'd7);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
      #1;
      check("pre_rst_stall", iss_stall, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_cnt", pend_cnt, 6'd0);
      check("async_rst_rdata", rdata, 64'h0);
      check("async_rst_rrdy", rrdy, 2'b11);
      check("async_rst_stall", iss_stall, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // The first edge after reset operates normally
      drive(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 5'd11);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      set_rd(5'd9, 5'd11);
      #1;
      check("post_rst_write", rdata[31:0], 32'hA5A5_A5A5);
      check("post_rst_issue_cnt", pend_cnt, 6'd1);
      check("post_rst_rrdy", rrdy, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
